vmm_fp16_accumulator: RTL and testbench

Streaming FP16 dot-product accumulator that sits directly downstream of the FP16 × reduced-precision multiplier in the VMM datapath. It consumes one FP16 product per cycle, sums the products of one vector exactly in a wide signed fixed-point register, and on the vector's last element converts the sum back to a single FP16 result. Output uses a valid/ready handshake. Rounding is truncation toward zero, matching the multiplier.

---
 rtl/vmm_fp16_accumulator_if.sv | 34 +++
 rtl/vmm_fp16_accumulator.sv | 162 ++++++++++++++++
 tb/tb_vmm_fp16_accumulator.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vmm_fp16_accumulator_if.sv
// ----------------------------------------------------------------------------
// vmm_fp16_accumulator_if
// Handshake bundle between the FP16 multiplier stream, the dot-product
// accumulator and the downstream consumer of the FP16 vector sums.
//   in_valid  : in_data / in_last valid
//   in_data   : FP16 product (sign, 5-bit exponent, 10-bit fraction)
//   in_last   : final element of the current vector
//   in_ready  : element accepted when in_valid & in_ready
//   out_valid : out_data valid, held until taken
//   out_data  : FP16 vector sum
//   out_ovf   : finite sum overflowed to +/-inf (qualified by out_valid)
//   out_ready : consumer accepts when out_valid & out_ready
// master = producer/consumer side, slave = accumulator side.
// ----------------------------------------------------------------------------
interface vmm_fp16_accumulator_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/vmm_fp16_accumulator.sv
// ----------------------------------------------------------------------------
// vmm_fp16_accumulator
// Streaming FP16 dot-product accumulator. Each accepted FP16 product is
// converted to signed fixed point (24 fraction bits) and summed exactly in
// an ACC_W-bit register. After the element flagged in_last, the sum is
// converted back to FP16 (truncation toward zero) and offered on a
// valid/ready output.
// Ports:
//   CLK     : clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : slave side of vmm_fp16_accumulator_if (in_* stream, out_* result)
// ----------------------------------------------------------------------------
module vmm_fp16_accumulator #(
    parameter int ACC_W = 48
) (
    input  logic                         CLK,
    input  logic                         Reset_n,
    vmm_fp16_accumulator_if.slave        bus
);

    typedef enum logic [1:0] {ACCUM, DRAIN, CONV, OUT} state_t;

    state_t                    state_q;
    state_t                    state_d;

    logic signed [ACC_W-1:0]   term_p1;
    logic signed [ACC_W-1:0]   acc_p2;
    logic                      nan_seen;
    logic                      pinf_seen;
    logic                      ninf_seen;
    logic [15:0]               out_data_q;
    logic                      out_ovf_q;

    logic                      in_fire;
    logic                      in_special;
    logic [16:0]               conv_res;

    // FP16 -> signed fixed point, 24 fraction bits. Magnitude is
    // {hidden, frac} << (e-1) for normals and frac for subnormals; the
    // largest finite value (0x7BFF) reaches bit 39. Inf/NaN contribute 0.
    function automatic logic signed [ACC_W-1:0] fp16_to_fixed(input logic [15:0] h);
        logic [4:0]              e;
        logic [39:0]             mag;
        logic signed [ACC_W-1:0] fix;
        e   = h[14:10];
        mag = 40'({(e != 5'd0), h[9:0]}) << ((e == 5'd0) ? 5'd0 : (e - 5'd1));
        if (e == 5'h1F) begin
            mag = '0;
        end
        fix = ACC_W'(mag);
        if (h[15]) begin
            fix = -fix;
        end
        return fix;
    endfunction

    // Fixed-point sum -> FP16 with truncation; returns {ovf, fp16}.
    // Special-value flags take priority; a zero sum is always +0.
    function automatic logic [16:0] fp16_from_acc(
        input logic signed [ACC_W-1:0] acc,
        input logic                    nan,
        input logic                    pinf,
        input logic                    ninf
    );
        logic             sign;
        logic [ACC_W-1:0] mag;
        int               p;
        logic [16:0]      r;
        sign = acc[ACC_W-1];
        mag  = sign ? -acc : acc;
        p    = -1;
        for (int i = 0; i < ACC_W; i++) begin
            if (mag[i]) p = i;
        end
        if (nan || (pinf && ninf)) begin
            r = {1'b0, 16'h7E00};
        end else if (pinf) begin
            r = {1'b0, 16'h7C00};
        end else if (ninf) begin
            r = {1'b0, 16'hFC00};
        end else if (p >= 40) begin
            r = {1'b1, sign, 5'h1F, 10'h000};
        end else if (p < 0) begin
            r = 17'h0_0000;
        end else if (p <= 9) begin
            r = {1'b0, sign, 5'd0, mag[9:0]};
        end else begin
            r = {1'b0, sign, 5'(p - 9), 10'(mag >> (p - 10))};
        end
        return r;
    endfunction

    assign in_fire    = bus.in_valid & bus.in_ready;
    assign in_special = (bus.in_data[14:10] == 5'h1F);
    assign conv_res   = fp16_from_acc(acc_p2, nan_seen, pinf_seen, ninf_seen);

    assign bus.out_data = out_data_q;
    assign bus.out_ovf  = out_ovf_q;

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ACCUM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && bus.in_last) state_d = DRAIN;
            end
            DRAIN: state_d = CONV;
            CONV:  state_d = OUT;
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            term_p1    <= '0;
            acc_p2     <= '0;
            nan_seen   <= 1'b0;
            pinf_seen  <= 1'b0;
            ninf_seen  <= 1'b0;
            out_data_q <= 16'h0000;
            out_ovf_q  <= 1'b0;
        end else begin
            // Stage 1: convert accepted element; bubbles load zero.
            term_p1 <= in_fire ? fp16_to_fixed(bus.in_data) : '0;

            // Stage 2: accumulate, or convert and clear for the next vector.
            if (state_q == CONV) begin
                {out_ovf_q, out_data_q} <= conv_res;
                acc_p2    <= '0;
                nan_seen  <= 1'b0;
                pinf_seen <= 1'b0;
                ninf_seen <= 1'b0;
            end else begin
                acc_p2 <= acc_p2 + term_p1;
                if (in_fire && in_special) begin
                    if (bus.in_data[9:0] != 10'd0) begin
                        nan_seen <= 1'b1;
                    end else if (bus.in_data[15]) begin
                        ninf_seen <= 1'b1;
                    end else begin
                        pinf_seen <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vmm_fp16_accumulator.sv
// ----------------------------------------------------------------------------
// tb_vmm_fp16_accumulator
// Directed bench for vmm_fp16_accumulator: reset state, exact sums,
// cancellation, subnormal results, overflow, special values, output
// backpressure and mid-vector reset. Expected values are hand-computed.
// ----------------------------------------------------------------------------
module tb_vmm_fp16_accumulator;

    logic CLK;
    logic Reset_n;
    int   checks;
    int   errors;

    vmm_fp16_accumulator_if bus ();

    vmm_fp16_accumulator #(.ACC_W(48)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Streams n elements back to back, checks the 3-edge latency, the result
    // and the handshake back into ACCUM.
    task automatic run_vec(input string tag, input int n,
                           input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3,
                           input logic [15:0] exp_data, input logic exp_ovf);
        logic [15:0] el [4];
        el[0] = e0; el[1] = e1; el[2] = e2; el[3] = e3;
        for (int i = 0; i < n; i++) begin
            check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b1;
            bus.in_data  = el[i];
            bus.in_last  = (i == n - 1);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 16'hFFFF;
        check({tag, "_drain_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_drain_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_conv_valid"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.out_data), 32'(exp_data));
        check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_taken_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_taken_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        Reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'h0000);
        check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
        Reset_n = 1'b1;
        tick();

        run_vec("one_plus_two",  2, 16'h3C00, 16'h4000, 16'h0, 16'h0, 16'h4200, 1'b0);
        run_vec("cancel_sub",    4, 16'h3C00, 16'hBC00, 16'h0001, 16'h0001, 16'h0002, 1'b0);
        run_vec("cancel_zero",   2, 16'h3C00, 16'hBC00, 16'h0, 16'h0, 16'h0000, 1'b0);
        run_vec("ovf_pos",       2, 16'h7BFF, 16'h7BFF, 16'h0, 16'h0, 16'h7C00, 1'b1);
        run_vec("ovf_neg",       2, 16'hFBFF, 16'hFBFF, 16'h0, 16'h0, 16'hFC00, 1'b1);
        run_vec("max_trunc",     2, 16'h7BFF, 16'h0001, 16'h0, 16'h0, 16'h7BFF, 1'b0);
        run_vec("inf_mix",       2, 16'h7C00, 16'hFC00, 16'h0, 16'h0, 16'h7E00, 1'b0);
        run_vec("inf_plus_one",  2, 16'h7C00, 16'h3C00, 16'h0, 16'h0, 16'h7C00, 1'b0);
        run_vec("ninf",          1, 16'hFC00, 16'h0, 16'h0, 16'h0, 16'hFC00, 1'b0);
        run_vec("nan",           1, 16'h7E01, 16'h0, 16'h0, 16'h0, 16'h7E00, 1'b0);
        run_vec("min_normal",    1, 16'h0400, 16'h0, 16'h0, 16'h0, 16'h0400, 1'b0);
        run_vec("neg_sum",       3, 16'hC000, 16'hBC00, 16'h3800, 16'h0, 16'hC100, 1'b0);

        // Backpressure: result 3C00 held while out_ready is low and the
        // producer keeps offering 4000/last; nothing may be consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h3C00;
        bus.in_last  = 1'b1;
        tick();
        bus.in_data  = 16'h4000;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_data",  32'(bus.out_data),  32'h3C00);
            check("bp_ready", 32'(bus.in_ready),  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        // in_valid still high with 4000/last: accepted on this edge.
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        tick();
        tick();
        check("bp_next_valid", 32'(bus.out_valid), 32'd1);
        check("bp_next_data",  32'(bus.out_data),  32'h4000);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset mid-vector after 3 of 6 elements.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h3C00;
            bus.in_last  = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        Reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        tick();
        Reset_n = 1'b1;
        tick();
        check("midrst_idle_valid", 32'(bus.out_valid), 32'd0);
        run_vec("after_rst", 1, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h3C00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
